// File: rtl/regfile_param_if.sv
// regfile_param_if: read/write bus of the parametrised register file
interface regfile_param_if #(
  parameter int WIDTH = 13,
  parameter int AW    = 3
);
  logic [AW-1:0]    RP;
  logic [AW-1:0]    RQ;
  logic [AW-1:0]    WA;
  logic [WIDTH-1:0] LD_DATA;
  logic             WR;
  logic             CLR_ALL;
  logic [WIDTH-1:0] DATAP;
  logic [WIDTH-1:0] DATAQ;
  logic             VALIDP;
  logic             VALIDQ;
  logic             WERR;
  modport master (
    output RP, RQ, WA, LD_DATA, WR, CLR_ALL,
    input  DATAP, DATAQ, VALIDP, VALIDQ, WERR
  );
  modport slave (
    input  RP, RQ, WA, LD_DATA, WR, CLR_ALL,
    output DATAP, DATAQ, VALIDP, VALIDQ, WERR
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: 2-read/1-write register file with valid bits, optional bypass/read register and sticky write error
module regfile_param #(
  parameter int WIDTH    = 13,
  parameter int DEPTH    = 5,
  parameter int AW       = 3,
  parameter int READ_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic           CLK,
  input  logic           CLRN,
  regfile_param_if.slave bus
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic             r_werr;
  logic [WIDTH:0]   w_p;
  logic [WIDTH:0]   w_q;

  if (DEPTH < 1 || DEPTH > 2**AW) begin : g_bad_depth
    $error("regfile_param: DEPTH must lie in 1..2**AW");
  end

  // {valid, data} seen at address a, including forwarding of this cycle's write when enabled
  function automatic logic [WIDTH:0] f_rd(input logic [AW-1:0] a, input logic wr, input logic clr,
                                          input logic [AW-1:0] wa, input logic [WIDTH-1:0] d);
    f_rd = (32'(a) >= DEPTH || (BYPASS != 0 && clr)) ? '0 :
           (BYPASS != 0 && wr && wa == a) ? {1'b1, d} : {r_valid[a], r_mem[a]};
  endfunction

  // read value of both ports before the optional output register
  always_comb begin
    w_p = f_rd(bus.RP, bus.WR, bus.CLR_ALL, bus.WA, bus.LD_DATA);
    w_q = f_rd(bus.RQ, bus.WR, bus.CLR_ALL, bus.WA, bus.LD_DATA);
  end

  // storage update: clear beats write, out-of-range writes only raise the sticky error
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN || bus.CLR_ALL) begin
      r_mem   <= '{default: '0};
      r_valid <= '0;
      r_werr  <= 1'b0;
    end else if (bus.WR) begin
      if (32'(bus.WA) < DEPTH) begin
        r_mem[bus.WA]   <= bus.LD_DATA;
        r_valid[bus.WA] <= 1'b1;
      end else begin
        r_werr <= 1'b1;
      end
    end
  end

  if (READ_REG != 0) begin : g_reg
    logic [WIDTH:0] r_p;
    logic [WIDTH:0] r_q;
    // one-cycle read latency: capture both port values each edge
    always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
        r_p <= '0;
        r_q <= '0;
      end else begin
        r_p <= w_p;
        r_q <= w_q;
      end
    end
    assign {bus.VALIDP, bus.DATAP} = r_p;
    assign {bus.VALIDQ, bus.DATAQ} = r_q;
  end else begin : g_comb
    assign {bus.VALIDP, bus.DATAP} = w_p;
    assign {bus.VALIDQ, bus.DATAQ} = w_q;
  end

  assign bus.WERR = r_werr;
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 5 x 13-bit two-read/one-write register file.
- Adds configurable width and depth, an optional registered (pipelined) read stage and write-to-read bypass.
- Adds per-entry valid tracking, a synchronous clear-all command and a sticky out-of-range write error flag.
- Sits between the game controller datapath and its ALU, holding timer, score and reaction-time operands.

Parameters:
WIDTH, 13, data bits per entry
DEPTH, 5, number of implemented entries (1..2**AW)
AW, 3, address width of RP/RQ/WA
READ_REG, 1, 1 = DATAP/DATAQ/VALIDP/VALIDQ registered (latency 1); 0 = combinational (latency 0)
BYPASS, 1, 1 = same-cycle write data forwarded to reads of that address; 0 = reads return pre-write contents

Ports:
CLK  in  1  clock, rising edge
CLRN  in  1  asynchronous active-low reset
RP  in  AW  read address, port P
RQ  in  AW  read address, port Q
WA  in  AW  write address
LD_DATA  in  WIDTH  write data
WR  in  1  write enable
CLR_ALL  in  1  synchronous clear of all entries, valid bits and WERR
DATAP  out  WIDTH  read data, port P
DATAQ  out  WIDTH  read data, port Q
VALIDP  out  1  entry at RP written since last reset/clear
VALIDQ  out  1  entry at RQ written since last reset/clear
WERR  out  1  sticky: write attempted to address >= DEPTH

Behaviour:
- Reset (CLRN=0, asynchronous, no clock needed):
  - All entries = 0 and all valid bits = 0.
  - WERR = 0.
  - Registered DATAP/DATAQ = 0 and VALIDP/VALIDQ = 0.
  - Reset asserted mid-operation overrides any in-flight write or read.
- Write (rising CLK, CLR_ALL=0, WR=1):
  - WA < DEPTH: mem[WA] <= LD_DATA, valid[WA] <= 1.
  - WA >= DEPTH: storage unchanged, WERR <= 1. WERR holds until CLR_ALL or reset.
- CLR_ALL=1 at rising CLK: all entries = 0, valid = 0, WERR = 0. CLR_ALL has priority over WR in the same cycle; the write is dropped and WERR is not set.
- Read value function for address A:
  - A >= DEPTH: data 0, valid 0.
  - BYPASS=1, WR=1, CLR_ALL=0, WA==A, A<DEPTH: data LD_DATA, valid 1.
  - Otherwise: data mem[A], valid valid[A].
  - BYPASS=1 and CLR_ALL=1: read value is 0 / valid 0.
- READ_REG=0:
  - DATAP/VALIDP = f(RP) and DATAQ/VALIDQ = f(RQ), combinationally.
  - Bypass makes a write visible before the edge.
- READ_REG=1:
  - Outputs load f(RP)/f(RQ) at each rising CLK; read latency 1 cycle.
  - With BYPASS=0, a read of an address written in the same cycle returns the old value; the new value appears one cycle later.
- Ports P and Q are fully independent. RP==RQ is legal and both ports return identical values.
- No write collisions are possible (single write port).
- Address width rule: DEPTH <= 2**AW, enforced by an elaboration-time check.

Test Plan:
- Reset then read: CLRN=0 -> DATAP=DATAQ=0, VALIDP=VALIDQ=0, WERR=0. Release reset, RP=0, RQ=4 -> DATAP=DATAQ=0, VALIDP=VALIDQ=0.
- Write/read all (defaults): write 13'h1A5 to 0, 13'h0FF to 4, 13'h1FFF to 2. Then RP=4, RQ=2 -> one cycle later DATAP=13'h0FF, DATAQ=13'h1FFF, both valid=1.
- Out of range: WR=1, WA=6, LD_DATA=13'h123 -> WERR=1 next cycle and stays 1. Reading RP=6 -> DATAP=0, VALIDP=0. Entries 0..4 unchanged.
- Bypass:
  - BYPASS=1, READ_REG=1: mem[3]=13'h010; same cycle WR=1, WA=3, LD_DATA=13'h020, RP=3 -> DATAP=13'h020 after the edge.
  - BYPASS=0, same stimulus -> DATAP=13'h010, then 13'h020 one cycle later.
- Clear priority: entries loaded, WERR=1; assert CLR_ALL=1 with WR=1, WA=1, LD_DATA=13'h055 -> after the edge all entries 0, valid 0, WERR=0, and mem[1]=0.
- Async reset mid-write plus param sweep: drop CLRN between edges while WR=1 -> outputs 0 immediately, no write lands. Repeat the write/read check with WIDTH=16, DEPTH=8, AW=3, READ_REG=0: write 16'hBEEF to 7 -> DATAP=16'hBEEF combinationally the same cycle.
